reg_sequencer: RTL and testbench

//   Timed register-write scheduler for the tone generator's 3-bit address / 5-bit data write bus.

---
 rtl/reg_sequencer_if.sv | 24 ++
 rtl/reg_sequencer.sv | 163 ++++++++++++++++
 tb/tb_reg_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_sequencer_if.sv
// Write-bus and program-load bundle for reg_sequencer.
// Slave is the sequencer side; master is the host/loader side.
interface reg_sequencer_if;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_word;
    logic        host_req;
    logic [2:0]  host_addr;
    logic [4:0]  host_data;
    logic        host_ack;
    logic        write_strobe;
    logic [2:0]  address;
    logic [4:0]  data;

    modport master (
        output load_valid, load_word, host_req, host_addr, host_data,
        input  load_ready, host_ack, write_strobe, address, data
    );

    modport slave (
        input  load_valid, load_word, host_req, host_addr, host_data,
        output load_ready, host_ack, write_strobe, address, data
    );
endinterface

// File: rtl/reg_sequencer.sv
// Timed register-write sequencer with host-priority write arbitration.
// Optional SEQ_LOOP_EN: replay the program from step 0 when loop is set.
module reg_sequencer #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int TICK_DIV = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_sequencer_if.slave    bus,
    input  logic              clear,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic              busy,
    output logic [AW-1:0]     step_idx,
    output logic              done
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [15:0]   mem [DEPTH];
    logic [AW:0]   count;
    logic [7:0]    delayCnt;
    logic [PW-1:0] presc;
    logic [15:0]   curWord;
    logic          hostGrant;
    logic          loadFire;
    logic          lastStep;
    logic          seqIssue;
    logic          doneNext;
    logic          stepClr;
    logic          stepInc;

`ifndef SEQ_LOOP_EN
    logic unusedLoop;
    assign unusedLoop = loop;
`endif

    assign curWord       = mem[step_idx];
    assign busy          = (state != IDLE);
    assign hostGrant     = bus.host_req && !bus.host_ack;
    assign bus.load_ready = (state == IDLE) && !count[AW] && !clear;
    assign loadFire      = bus.load_valid && bus.load_ready;
    assign lastStep      = ({1'b0, step_idx} == (count - 1'b1));

    // Program storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (loadFire) begin
            mem[count[AW-1:0]] <= bus.load_word;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and step control; stop overrides everything.
    always_comb begin
        stateNext = state;
        seqIssue  = 1'b0;
        doneNext  = 1'b0;
        stepClr   = 1'b0;
        stepInc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && (count != '0)) begin
                    stateNext = ISSUE;
                    stepClr   = 1'b1;
                end
            end
            ISSUE: begin
                if (!hostGrant) begin
                    seqIssue  = 1'b1;
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (delayCnt == 8'd0) begin
                    if (!lastStep) begin
                        stepInc   = 1'b1;
                        stateNext = ISSUE;
`ifdef SEQ_LOOP_EN
                    end else if (loop) begin
                        stepClr   = 1'b1;
                        stateNext = ISSUE;
`endif
                    end else begin
                        doneNext  = 1'b1;
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
        if (stop) begin
            stateNext = IDLE;
            seqIssue  = 1'b0;
            doneNext  = 1'b0;
            stepClr   = 1'b0;
            stepInc   = 1'b0;
        end
    end

    // Bus outputs, step index, tempo timer and program count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.write_strobe <= 1'b0;
            bus.host_ack     <= 1'b0;
            bus.address      <= '0;
            bus.data         <= '0;
            done             <= 1'b0;
            step_idx         <= '0;
            delayCnt         <= '0;
            presc            <= '0;
            count            <= '0;
        end else begin
            bus.write_strobe <= hostGrant || seqIssue;
            bus.host_ack     <= hostGrant;
            done             <= doneNext;
            if (hostGrant) begin
                bus.address <= bus.host_addr;
                bus.data    <= bus.host_data;
            end else if (seqIssue) begin
                bus.address <= curWord[15:13];
                bus.data    <= curWord[12:8];
            end
            if (stepClr) begin
                step_idx <= '0;
            end else if (stepInc) begin
                step_idx <= step_idx + 1'b1;
            end
            if (seqIssue) begin
                delayCnt <= curWord[7:0];
                presc    <= '0;
            end else if ((state == WAIT) && (delayCnt != 8'd0)) begin
                if (presc == PW'(TICK_DIV - 1)) begin
                    presc    <= '0;
                    delayCnt <= delayCnt - 8'd1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
            if ((state == IDLE) && clear) begin
                count <= '0;
            end else if (loadFire) begin
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reg_sequencer.sv
// Directed self-checking bench for reg_sequencer (TICK_DIV=4).
// Covers loop behaviour in both SEQ_LOOP_EN builds.
module tb_reg_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       start;
    logic       stop;
    logic       loop;
    logic       busy;
    logic [3:0] step_idx;
    logic       done;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;
    int n;
    logic flag;
    logic doneSeen;
    logic [15:0] w;

    reg_sequencer_if bus ();

    reg_sequencer #(
        .DEPTH(16),
        .AW(4),
        .TICK_DIV(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .clear(clear),
        .start(start),
        .stop(stop),
        .loop(loop),
        .busy(busy),
        .step_idx(step_idx),
        .done(done)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    // Hard stop in case something wedges.
    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic loadWord(input logic [15:0] word);
        bus.load_valid = 1'b1;
        bus.load_word  = word;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic waitStrobe(input int maxCyc, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
            if (done) doneSeen = 1'b1;
        end while (!bus.write_strobe && cyc < maxCyc);
    endtask

    function automatic logic [8:0] busVal();
        return {bus.write_strobe, bus.address, bus.data};
    endfunction

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        loop  = 1'b0;
        doneSeen = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_word  = '0;
        bus.host_req   = 1'b0;
        bus.host_addr  = '0;
        bus.host_data  = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_strobe", bus.write_strobe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", bus.load_ready, 1);
        chk("rst_step", step_idx, 0);
        chk("rst_ack", bus.host_ack, 0);
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_start_busy", busy, 0);
        tick();
        chk("empty_start_strobe", bus.write_strobe, 0);

        // Two-step playback
        loadWord(16'h0A00);
        loadWord(16'h4802);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s2_busy", busy, 1);
        chk("s2_nostrobe", bus.write_strobe, 0);
        tick();
        chk("s2_step0_bus", busVal(), {1'b1, 3'd0, 5'h0A});
        chk("s2_step0_idx", step_idx, 0);
        tick();
        chk("s2_strobe_1cyc", bus.write_strobe, 0);
        tick();
        chk("s2_step1_bus", busVal(), {1'b1, 3'd2, 5'h08});
        chk("s2_step1_idx", step_idx, 1);
        flag = 1'b0;
        repeat (8) begin
            tick();
            if (done || bus.write_strobe || !busy) flag = 1'b1;
        end
        chk("s2_wait_quiet", flag, 0);
        tick();
        chk("s2_done", done, 1);
        chk("s2_idle", busy, 0);
        chk("s2_last_idx", step_idx, 1);
        tick();
        chk("s2_done_pulse", done, 0);

        // Fill and clear
        clear = 1'b1;
        #1;
        chk("clr_ready_low", bus.load_ready, 0);
        tick();
        clear = 1'b0;
        #1;
        chk("clr_ready_high", bus.load_ready, 1);
        for (int i = 0; i < 16; i++) begin
            w = {i[2:0], 5'(i + 1), 8'd0};
            loadWord(w);
        end
        chk("full_ready_low", bus.load_ready, 0);
        bus.load_valid = 1'b1;
        bus.load_word  = 16'hFFFF;
        tick();
        bus.load_valid = 1'b0;
        chk("full_still_low", bus.load_ready, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("full_word0_kept", busVal(), {1'b1, 3'd0, 5'd1});
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("full_stop_idle", busy, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        chk("clear_ready", bus.load_ready, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clear_count0", busy, 0);

        // Host priority during ISSUE
        loadWord(16'h2301);
        loadWord(16'h7100);
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.host_req  = 1'b1;
        bus.host_addr = 3'd5;
        bus.host_data = 5'h07;
        tick();
        chk("host_first_bus", busVal(), {1'b1, 3'd5, 5'h07});
        chk("host_first_ack", bus.host_ack, 1);
        tick();
        chk("host_seq_bus", busVal(), {1'b1, 3'd1, 5'h03});
        chk("host_seq_noack", bus.host_ack, 0);
        tick();
        chk("host_regrant_bus", busVal(), {1'b1, 3'd5, 5'h07});
        chk("host_regrant_ack", bus.host_ack, 1);
        bus.host_req = 1'b0;
        flag = 1'b0;
        repeat (4) begin
            tick();
            if (bus.write_strobe) flag = 1'b1;
        end
        chk("host_wait_quiet", flag, 0);
        tick();
        chk("host_step1_bus", busVal(), {1'b1, 3'd3, 5'h11});
        chk("host_step1_idx", step_idx, 1);
        tick();
        chk("host_done", done, 1);

        // Stop mid-program and replay
        clear = 1'b1;
        tick();
        clear = 1'b0;
        loadWord(16'h0103);
        loadWord(16'h2203);
        loadWord(16'h4303);
        start = 1'b1;
        tick();
        start = 1'b0;
        waitStrobe(20, n);
        chk("stop_s0_lat", n, 1);
        chk("stop_s0_bus", busVal(), {1'b1, 3'd0, 5'd1});
        waitStrobe(30, n);
        chk("stop_s1_gap", n, 14);
        chk("stop_s1_bus", busVal(), {1'b1, 3'd1, 5'd2});
        repeat (3) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_idle", busy, 0);
        flag = 1'b0;
        repeat (30) begin
            tick();
            if (bus.write_strobe || done || busy) flag = 1'b1;
        end
        chk("stop_quiet", flag, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("replay_bus", busVal(), {1'b1, 3'd0, 5'd1});
        chk("replay_idx", step_idx, 0);

        // Async reset during a strobe
        waitStrobe(30, n);
        chk("arst_pre_strobe", busVal(), {1'b1, 3'd1, 5'd2});
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bus", busVal(), 0);
        chk("arst_busy", busy, 0);
        chk("arst_idx", step_idx, 0);
        chk("arst_ready", bus.load_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Loop request
        loadWord(16'h2400);
        loadWord(16'hDF00);
        loop = 1'b1;
        doneSeen = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef SEQ_LOOP_EN
        waitStrobe(8, n);
        chk("loop_first", busVal(), {1'b1, 3'd1, 5'h04});
        for (int k = 1; k < 6; k++) begin
            waitStrobe(8, n);
            chk("loop_gap", n, 2);
            chk("loop_idx", step_idx, 32'(k % 2));
        end
        chk("loop_busy", busy, 1);
        chk("loop_nodone", doneSeen, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("loop_arst_bus", busVal(), 0);
        chk("loop_arst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
`else
        waitStrobe(8, n);
        chk("noloop_s0", busVal(), {1'b1, 3'd1, 5'h04});
        waitStrobe(8, n);
        chk("noloop_s1", busVal(), {1'b1, 3'd6, 5'h1F});
        chk("noloop_gap", n, 2);
        tick();
        chk("noloop_done", done, 1);
        chk("noloop_idle", busy, 0);
`endif
        loop = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
